fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter XLEN, default 32, address/data width; legal values 32 and 64.
REQ-002 Parameter DEPTH, default 4, instruction queue entries; power of two, at least 2.
REQ-003 Parameter RESET_PC, default 0, first fetch address after reset.
REQ-004 clk  input  1  sole clock, rising-edge.
REQ-005 reset_n  input  1  asynchronous, active-low reset.
REQ-006 i_redirect  input  1  taken branch/jump; flush and restart fetch.
REQ-007 i_redirect_pc  input  XLEN  redirect target.
REQ-008 o_imem_req  output  1  read request to instruction memory, fixed 1-cycle latency.
REQ-009 o_imem_addr  output  XLEN  request address.
REQ-010 i_imem_rdata  input  32  instruction word, valid the cycle after o_imem_req.
REQ-011 o_fetch_valid  output  1  queue head holds a valid instruction.
REQ-012 i_fetch_ready  input  1  decode accepts head.
REQ-013 o_fetch_pc, o_fetch_pc_inc  output  XLEN  head PC, head PC+4.
REQ-014 o_fetch_inst  output  32  head instruction.

Function
REQ-015 Internal fetch PC register; request issued when reset_n high, i_redirect low, and (count + inflight - pop) < DEPTH; pop = o_fetch_valid && i_fetch_ready.
REQ-016 On issue: o_imem_addr = fetch PC, fetch PC advances by 4, modulo 2^XLEN (all-ones region wraps to 0).
REQ-017 Response pushed with its request PC at the end of the return cycle; o_fetch_valid asserts the following cycle (2 cycles request-to-valid).
REQ-018 With i_fetch_ready held high, throughput 1 instruction/cycle for every DEPTH >= 2.
REQ-019 Push and pop in the same cycle allowed; count unchanged; overflow impossible by REQ-015.
REQ-020 Empty queue: o_fetch_valid 0, o_fetch_inst 32'h00000013 (NOP), o_fetch_pc 0.
REQ-021 Head outputs hold stable while o_fetch_valid && !i_fetch_ready.
REQ-022 i_redirect: queue emptied, in-flight response discarded, fetch PC = i_redirect_pc with bits [1:0] forced to 0, no request that cycle.
REQ-023 Redirect takes priority over simultaneous pop and push; o_fetch_valid is 0 the cycle after redirect.
REQ-024 Request at redirect target issued the cycle after redirect; back-to-back redirects each restart.
REQ-025 o_fetch_pc_inc = o_fetch_pc + 4 modulo 2^XLEN.

Reset
REQ-026 reset_n low: fetch PC = RESET_PC, queue empty, inflight cleared, o_imem_req 0, o_fetch_valid 0, outputs at REQ-020 values, counters 0.
REQ-027 Reset asserted mid-operation discards queue and in-flight response immediately; first request the first cycle after release.

Configuration
REQ-028 Macro FETCH_PERF_EN defined: 32-bit outputs o_perf_fetched (pops) and o_perf_stall (cycles with o_fetch_valid && !i_fetch_ready), saturating at all-ones; undefined: ports and counters absent, function otherwise identical.

Structure
REQ-029 Package fetch_pkg holds XLEN default, NOP constant, PC increment constant 4, and packed struct fetch_entry_t {pc, inst}.
REQ-030 Queue is sub-module fetch_fifo (DEPTH, entry type fetch_entry_t, push/pop/flush, count); fetch_unit holds PC, issue logic and inflight tracking.

Verification
REQ-031 Reset release, RESET_PC=0, ready=1 -> requests 0x0,0x4,0x8 in consecutive cycles; o_fetch_valid first high cycle 2, PCs 0x0,0x4,0x8 on consecutive cycles.
REQ-032 DEPTH=4, ready=0 -> exactly 4 requests, o_imem_req then 0, head PC 0x0 held; ready=1 -> one pop per cycle, no gap.
REQ-033 Redirect to 0x103 while response for 0x8 in flight -> 0x8 never delivered, next delivered PC 0x100, o_fetch_pc_inc 0x104.
REQ-034 XLEN=32, redirect to 0xFFFFFFFC -> delivered PCs 0xFFFFFFFC then 0x00000000; o_fetch_pc_inc of first = 0.
REQ-035 FETCH_PERF_EN, 10 pops and 3 stalled cycles -> o_perf_fetched 10, o_perf_stall 3; reset_n pulse mid-run -> both 0, queue empty, next request at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch slice.
package fetch_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam int unsigned XLEN_MAX     = 64;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;
  localparam int unsigned PC_INC       = 4;

  // pc is sized for the widest legal XLEN; narrower builds zero-extend on push.
  typedef struct packed {
    logic [XLEN_MAX-1:0] pc;
    logic [31:0]         inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Redirect, instruction-memory and decode handshake signals of the fetch unit.
interface fetch_unit_if #(
  parameter int unsigned XLEN = fetch_pkg::XLEN_DEFAULT
);
  logic            i_redirect;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_imem_req;
  logic [XLEN-1:0] o_imem_addr;
  logic [31:0]     i_imem_rdata;
  logic            o_fetch_valid;
  logic            i_fetch_ready;
  logic [XLEN-1:0] o_fetch_pc;
  logic [XLEN-1:0] o_fetch_pc_inc;
  logic [31:0]     o_fetch_inst;

  modport master (
    input  i_redirect, i_redirect_pc, i_imem_rdata, i_fetch_ready,
    output o_imem_req, o_imem_addr, o_fetch_valid, o_fetch_pc, o_fetch_pc_inc, o_fetch_inst
  );

  modport slave (
    output i_redirect, i_redirect_pc, i_imem_rdata, i_fetch_ready,
    input  o_imem_req, o_imem_addr, o_fetch_valid, o_fetch_pc, o_fetch_pc_inc, o_fetch_inst
  );
endinterface

// File: rtl/fetch_fifo.sv
// Instruction queue: circular buffer of fetch entries with flush and occupancy count.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  fetch_entry_t     push_data,
  input  logic             pop,
  output fetch_entry_t     head,
  output logic [CNT_W-1:0] count
);

  fetch_entry_t     mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, 1-cycle imem issue, in-flight tracking, decode queue.
// Optional perf counters enabled by defining FETCH_PERF_EN.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   XLEN     = XLEN_DEFAULT,
  parameter int unsigned   DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic        clk,
  input  logic        reset_n,
  fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] o_perf_fetched,
  output logic [31:0] o_perf_stall
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [XLEN-1:0]  fetch_pc;
  logic [XLEN-1:0]  inflight_pc;
  logic             inflight;
  logic [CNT_W-1:0] count;
  logic [CNT_W:0]   occupancy;
  logic             fetch_valid;
  logic             pop;
  logic             push;
  logic             issue;
  logic [XLEN-1:0]  head_pc;
  fetch_entry_t     head;
  fetch_entry_t     push_data;
  logic             unused_head_pc;

  always_comb begin
    fetch_valid = (count != '0);
    pop         = fetch_valid && bus.i_fetch_ready;
    // Slots already promised (queued + in flight) minus the one leaving this cycle.
    occupancy   = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
    issue       = reset_n && !bus.i_redirect && (occupancy < (CNT_W+1)'(DEPTH));
    push        = inflight && !bus.i_redirect;

    push_data      = '0;
    push_data.pc   = XLEN_MAX'(inflight_pc);
    push_data.inst = bus.i_imem_rdata;

    head_pc = fetch_valid ? head.pc[XLEN-1:0] : '0;

    bus.o_imem_req     = issue;
    bus.o_imem_addr    = fetch_pc;
    bus.o_fetch_valid  = fetch_valid;
    bus.o_fetch_pc     = head_pc;
    bus.o_fetch_pc_inc = head_pc + XLEN'(PC_INC);
    bus.o_fetch_inst   = fetch_valid ? head.inst : NOP_INST;
  end

  assign unused_head_pc = ^head.pc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.i_redirect) begin
      fetch_pc <= {bus.i_redirect_pc[XLEN-1:2], 2'b00};
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + XLEN'(PC_INC);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (bus.i_redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_perf_fetched <= '0;
      o_perf_stall   <= '0;
    end else begin
      if (pop && (o_perf_fetched != '1))
        o_perf_fetched <= o_perf_fetched + 1'b1;
      if (fetch_valid && !bus.i_fetch_ready && (o_perf_stall != '1))
        o_perf_stall <= o_perf_stall + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: cycle vector table, scoreboard, and corner sequences.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus();

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  fetch_unit #(
    .XLEN     (XLEN),
    .DEPTH    (DEPTH),
    .RESET_PC (RST_PC)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef FETCH_PERF_EN
    ,
    .o_perf_fetched (perf_fetched),
    .o_perf_stall   (perf_stall)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] delivered[$];
  logic [31:0] exp_addr;
  logic        last_req;
  logic [31:0] last_addr;

  typedef struct {
    logic        rdy;
    logic        redir;
    logic [31:0] rpc;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vt[16];

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {a[31:2], 2'b11} ^ 32'h5A3C_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic redir, input logic [31:0] rpc);
    bus.i_fetch_ready = rdy;
    bus.i_redirect    = redir;
    bus.i_redirect_pc = rpc;
    #1;
  endtask

  // Scoreboard bookkeeping for the current cycle, then advance to the next negedge.
  task automatic commit();
    exp_t e;
    if (!bus.o_fetch_valid) begin
      chk("empty_inst", bus.o_fetch_inst, NOP_INST);
      chk("empty_pc", bus.o_fetch_pc, 32'h0);
    end
    if (bus.i_redirect) begin
      chk("req_during_redirect", 32'(bus.o_imem_req), 32'h0);
    end else if (bus.o_fetch_valid && bus.i_fetch_ready) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_underflow: delivered pc %h expected no delivery", bus.o_fetch_pc);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", bus.o_fetch_pc, e.pc);
        chk("sb_pc_inc", bus.o_fetch_pc_inc, e.pc + 32'd4);
        chk("sb_inst", bus.o_fetch_inst, e.inst);
        delivered.push_back(bus.o_fetch_pc);
      end
    end
    if (bus.o_imem_req) begin
      chk("req_addr", bus.o_imem_addr, exp_addr);
      sb.push_back('{pc: exp_addr, inst: inst_of(exp_addr)});
      exp_addr = exp_addr + 32'd4;
    end
    if (bus.i_redirect) begin
      sb.delete();
      exp_addr = {bus.i_redirect_pc[31:2], 2'b00};
    end
    last_req  = bus.o_imem_req;
    last_addr = bus.o_imem_addr;
    @(negedge clk);
    bus.i_imem_rdata = last_req ? inst_of(last_addr) : 32'hBAD0_BAD0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"}, 32'(bus.o_imem_req), 32'h0);
    chk({tag, "_valid"}, 32'(bus.o_fetch_valid), 32'h0);
    chk({tag, "_inst"}, bus.o_fetch_inst, NOP_INST);
    chk({tag, "_pc"}, bus.o_fetch_pc, 32'h0);
    chk({tag, "_pc_inc"}, bus.o_fetch_pc_inc, 32'h4);
  endtask

  task automatic do_reset(input string tag);
    reset_n           = 1'b0;
    bus.i_fetch_ready = 1'b0;
    bus.i_redirect    = 1'b0;
    bus.i_redirect_pc = '0;
    bus.i_imem_rdata  = 32'hBAD0_BAD0;
    sb.delete();
    exp_addr = RST_PC;
    #1;
    check_reset_outputs(tag);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h00,  1'b0, 32'h0};
    vt[1]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h04,  1'b0, 32'h0};
    vt[2]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h08,  1'b1, 32'h0};
    vt[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h0C,  1'b1, 32'h0};
    vt[4]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    vt[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h0,   1'b1, 32'h0};
    vt[6]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h0};
    vt[7]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h4};
    vt[8]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'h8};
    vt[9]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'hC};
    vt[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h10};
    vt[11] = '{1'b1, 1'b1, 32'h103, 1'b0, 32'h0,   1'b1, 32'h14};
    vt[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h100, 1'b0, 32'h0};
    vt[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h104, 1'b0, 32'h0};
    vt[14] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h108, 1'b1, 32'h100};
    vt[15] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h10C, 1'b1, 32'h104};

    // Table: fill with ready low, drain, then redirect to an unaligned target.
    do_reset("rst0");
    for (int unsigned i = 0; i < 16; i++) begin
      drive(vt[i].rdy, vt[i].redir, vt[i].rpc);
      chk($sformatf("vec%0d_req", i), 32'(bus.o_imem_req), 32'(vt[i].exp_req));
      if (vt[i].exp_req)
        chk($sformatf("vec%0d_addr", i), bus.o_imem_addr, vt[i].exp_addr);
      chk($sformatf("vec%0d_valid", i), 32'(bus.o_fetch_valid), 32'(vt[i].exp_valid));
      if (vt[i].exp_valid) begin
        chk($sformatf("vec%0d_pc", i), bus.o_fetch_pc, vt[i].exp_pc);
        chk($sformatf("vec%0d_pc_inc", i), bus.o_fetch_pc_inc, vt[i].exp_pc + 32'd4);
        chk($sformatf("vec%0d_inst", i), bus.o_fetch_inst, inst_of(vt[i].exp_pc));
      end
      commit();
    end

    // Startup latency with ready held high.
    do_reset("rst1");
    for (int unsigned k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      if (k < 3) begin
        chk("start_req", 32'(bus.o_imem_req), 32'h1);
        chk("start_addr", bus.o_imem_addr, 32'(4 * k));
      end
      chk("start_valid", 32'(bus.o_fetch_valid), 32'(k >= 2));
      if (k >= 2) chk("start_pc", bus.o_fetch_pc, 32'(4 * (k - 2)));
      commit();
    end

    // Redirect near the top of the address space must wrap to zero.
    delivered.delete();
    drive(1'b1, 1'b1, 32'hFFFF_FFFC);
    commit();
    drive(1'b1, 1'b0, 32'h0);
    chk("redir_next_valid", 32'(bus.o_fetch_valid), 32'h0);
    chk("redir_target_req", 32'(bus.o_imem_req), 32'h1);
    commit();
    for (int unsigned k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      commit();
    end
    chk("wrap_count_ok", 32'(delivered.size() >= 2), 32'h1);
    if (delivered.size() >= 2) begin
      chk("wrap_first_pc", delivered[0], 32'hFFFF_FFFC);
      chk("wrap_second_pc", delivered[1], 32'h0000_0000);
    end

    // Back-to-back redirects: only the second target is fetched.
    drive(1'b1, 1'b1, 32'h0000_0200);
    commit();
    drive(1'b1, 1'b1, 32'h0000_0300);
    commit();
    drive(1'b1, 1'b0, 32'h0);
    chk("b2b_addr", bus.o_imem_addr, 32'h300);
    commit();

    // Asynchronous reset in the middle of a cycle with a full queue.
    for (int unsigned k = 0; k < 4; k++) begin
      drive(1'b0, 1'b0, 32'h0);
      commit();
    end
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    sb.delete();
    exp_addr = RST_PC;
    @(negedge clk);
    reset_n = 1'b1;
    drive(1'b1, 1'b0, 32'h0);
    chk("post_rst_req", 32'(bus.o_imem_req), 32'h1);
    chk("post_rst_addr", bus.o_imem_addr, RST_PC);
    commit();
    drive(1'b1, 1'b0, 32'h0);
    commit();
    drive(1'b1, 1'b0, 32'h0);
    chk("post_rst_valid", 32'(bus.o_fetch_valid), 32'h1);
    chk("post_rst_pc", bus.o_fetch_pc, RST_PC);
    commit();

`ifdef FETCH_PERF_EN
    do_reset("rst_perf");
    #1;
    chk("perf_fetched_init", perf_fetched, 32'h0);
    chk("perf_stall_init", perf_stall, 32'h0);
    for (int unsigned k = 0; k < 5; k++) begin
      drive(1'b0, 1'b0, 32'h0);
      commit();
    end
    for (int unsigned k = 0; k < 10; k++) begin
      drive(1'b1, 1'b0, 32'h0);
      commit();
    end
    drive(1'b0, 1'b0, 32'h0);
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
    commit();
    do_reset("rst_perf2");
    #1;
    chk("perf_fetched_clr", perf_fetched, 32'h0);
    chk("perf_stall_clr", perf_stall, 32'h0);
    drive(1'b1, 1'b0, 32'h0);
    chk("perf_rst_addr", bus.o_imem_addr, RST_PC);
    commit();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
